// File: rtl/ins_cache_assoc.sv
// ins_cache_assoc: N-way set-associative read-only instruction cache with true-LRU replacement, flush and perf counters
//   clock, reset (async, active-high)
//   read, address        : fetch request from IF stage
//   readdata, busywait   : instruction (valid on same-cycle hit) and pipeline stall
//   flush                : one-cycle pulse invalidating every line (fence.i)
//   mem_read, mem_address, mem_readdata, mem_busywait : block-wide main memory port
//   hit_count, miss_count : saturating fetch counters
module ins_cache_assoc #(
   parameter int ADDR_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int NUM_SETS        = 8,
   parameter int NUM_WAYS        = 2
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          read,
   input  logic [ADDR_WIDTH-1:0]                         address,
   output logic [31:0]                                   readdata,
   output logic                                          busywait,
   input  logic                                          flush,
   output logic                                          mem_read,
   output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-3:0] mem_address,
   input  logic [32*WORDS_PER_BLOCK-1:0]                 mem_readdata,
   input  logic                                          mem_busywait,
   output logic [31:0]                                   hit_count,
   output logic [31:0]                                   miss_count
);
   localparam int OFF = $clog2(WORDS_PER_BLOCK);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = ADDR_WIDTH - IDX - OFF - 2;
   localparam int BLK = 32 * WORDS_PER_BLOCK;
   localparam int AW  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

   typedef enum logic {IDLE, MEM_READ} state_t;
   typedef logic [NUM_WAYS-1:0][AW-1:0] age_t;

   state_t              state_q, state_d;
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
   age_t                age_q [NUM_SETS];
   age_t                age_d [NUM_SETS];
   logic [TAG-1:0]      tag_q [NUM_SETS][NUM_WAYS];
   logic [BLK-1:0]      data_q [NUM_SETS][NUM_WAYS];
   logic [TAG-1:0]      lat_tag_q, lat_tag_d;
   logic [IDX-1:0]      lat_idx_q, lat_idx_d;
   logic [AW-1:0]       lat_way_q, lat_way_d;
   logic                discard_q, discard_d;
   logic [31:0]         hit_count_q, hit_count_d, miss_count_q, miss_count_d;
   logic [TAG-1:0]      tag_in;
   logic [IDX-1:0]      idx_in;
   logic [OFF-1:0]      off_in;
   logic                hit, fill, unused_addr;
   logic [AW-1:0]       hit_way, lru_way, victim;

   assign tag_in      = address[ADDR_WIDTH-1:IDX+OFF+2];
   assign idx_in      = address[IDX+OFF+1:OFF+2];
   assign off_in      = address[OFF+1:2];
   assign unused_addr = &{1'b0, address[1:0]};

   // Accessed way becomes age 0; ways younger than its old age grow one older.
   function automatic age_t touch(input age_t row, input logic [AW-1:0] way);
      age_t t = row;
      for (int w = 0; w < NUM_WAYS; w++)
         if (AW'(w) == way) t[w] = '0;
         else if (row[w] < row[way]) t[w] = row[w] + 1'b1;
      return t;
   endfunction

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      lru_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[idx_in][w] && tag_q[idx_in][w] == tag_in) begin
            hit     = read;
            hit_way = AW'(w);
         end
         if (age_q[idx_in][w] == AW'(NUM_WAYS - 1)) lru_way = AW'(w);
      end
      victim = lru_way;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_q[idx_in][w]) victim = AW'(w);
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      age_d        = age_q;
      lat_tag_d    = lat_tag_q;
      lat_idx_d    = lat_idx_q;
      lat_way_d    = lat_way_q;
      discard_d    = discard_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      fill         = 1'b0;
      if (flush) valid_d = '{default: '0};
      if (state_q == IDLE) begin
         if (hit) begin
            hit_count_d = hit_count_q + {31'b0, hit_count_q != '1};
            if (!flush) age_d[idx_in] = touch(age_q[idx_in], hit_way);
         end else if (read) begin
            miss_count_d = miss_count_q + {31'b0, miss_count_q != '1};
            lat_tag_d    = tag_in;
            lat_idx_d    = idx_in;
            lat_way_d    = victim;
            state_d      = MEM_READ;
         end
      end else begin
         // A flush seen at any point of the fill (including its last edge) lands the block invalid.
         discard_d = (discard_q || flush) && mem_busywait;
         if (!mem_busywait) begin
            fill                          = 1'b1;
            valid_d[lat_idx_q][lat_way_q] = !(discard_q || flush);
            age_d[lat_idx_q]              = touch(age_q[lat_idx_q], lat_way_q);
            state_d                       = IDLE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         valid_q      <= '{default: '0};
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               age_q[s][w] <= AW'(NUM_WAYS - 1 - w);
         lat_tag_q    <= '0;
         lat_idx_q    <= '0;
         lat_way_q    <= '0;
         discard_q    <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         age_q        <= age_d;
         lat_tag_q    <= lat_tag_d;
         lat_idx_q    <= lat_idx_d;
         lat_way_q    <= lat_way_d;
         discard_q    <= discard_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (fill) begin
         data_q[lat_idx_q][lat_way_q] <= mem_readdata;
         tag_q[lat_idx_q][lat_way_q]  <= lat_tag_q;
      end
   end

   assign readdata    = (hit && state_q == IDLE) ? data_q[idx_in][hit_way][32*off_in +: 32] : '0;
   assign busywait    = (state_q == IDLE && read && !hit) || state_q == MEM_READ;
   assign mem_read    = state_q == MEM_READ;
   assign mem_address = mem_read ? {lat_tag_q, lat_idx_q} : '0;
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;
endmodule

// File: tb/tb_ins_cache_assoc.sv
// tb_ins_cache_assoc: directed table-driven bench for ins_cache_assoc (2-way, 8 sets, 4 words)
module tb_ins_cache_assoc;
   logic         clock = 1'b0, reset = 1'b1, read = 1'b0, flush = 1'b0;
   logic [31:0]  address = '0;
   logic [31:0]  readdata, hit_count, miss_count, ba;
   logic         busywait, mem_read, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   int           mcnt;
   int           n_chk = 0, n_fail = 0;
   logic [31:0]  hc = 0, mc = 0;

   typedef struct {
      logic        rd;
      logic [31:0] a;
      logic        fl;
      logic        busy;
      logic [31:0] data;
      logic        mrd;
      logic [27:0] ma;
      logic [31:0] hc;
      logic [31:0] mc;
   } vec_t;
   vec_t tbl[$];

   ins_cache_assoc dut (
      .clock(clock), .reset(reset), .read(read), .address(address),
      .readdata(readdata), .busywait(busywait), .flush(flush),
      .mem_read(mem_read), .mem_address(mem_address), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   // Memory: busy for the first 3 cycles of a request, ready on the 4th.
   always @(posedge clock or posedge reset)
      if (reset) mcnt <= 0;
      else mcnt <= mem_read ? mcnt + 1 : 0;
   assign mem_busywait = mem_read && mcnt < 3;
   assign ba           = {mem_address, 4'b0};
   assign mem_readdata = {ba + 32'd12, ba + 32'd8, ba + 32'd4, ba};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic rd, input logic [31:0] a, input logic fl, input logic busy,
                          input logic [31:0] data, input logic mrd, input logic [27:0] ma);
      tbl.push_back('{rd, a, fl, busy, data, mrd, ma, hc, mc});
   endtask

   task automatic add_hit(input logic [31:0] a);
      add_vec(1'b1, a, 1'b0, 1'b0, a, 1'b0, 28'h0);
      hc++;
   endtask

   // Miss cycle, four MEM_READ cycles, then the hit that follows the fill.
   task automatic add_miss(input logic [31:0] a, input logic [27:0] ma);
      add_vec(1'b1, a, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0);
      mc++;
      for (int k = 0; k < 4; k++) add_vec(1'b1, a, 1'b0, 1'b1, 32'h0, 1'b1, ma);
      add_hit(a);
   endtask

   task automatic run_tbl;
      foreach (tbl[i]) begin
         read    = tbl[i].rd;
         address = tbl[i].a;
         flush   = tbl[i].fl;
         @(negedge clock);
         chk($sformatf("v%0d@%h readdata", i, tbl[i].a), readdata, tbl[i].data);
         chk($sformatf("v%0d@%h busywait", i, tbl[i].a), {31'b0, busywait}, {31'b0, tbl[i].busy});
         chk($sformatf("v%0d@%h mem_read", i, tbl[i].a), {31'b0, mem_read}, {31'b0, tbl[i].mrd});
         chk($sformatf("v%0d@%h mem_address", i, tbl[i].a), {4'b0, mem_address}, {4'b0, tbl[i].ma});
         chk($sformatf("v%0d@%h hit_count", i, tbl[i].a), hit_count, tbl[i].hc);
         chk($sformatf("v%0d@%h miss_count", i, tbl[i].a), miss_count, tbl[i].mc);
         @(posedge clock);
         #1;
      end
      tbl.delete();
      read  = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #12 reset = 1'b0;
      @(posedge clock);
      #1;
      // Reset state
      add_vec(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 28'h0);
      // Cold miss, then same-block hits
      add_miss(32'h084, 28'h008);
      add_hit(32'h080);
      add_hit(32'h088);
      add_hit(32'h08C);
      // LRU eviction in set 0
      add_miss(32'h000, 28'h000);
      add_hit(32'h080);
      add_hit(32'h000);
      add_miss(32'h100, 28'h010);
      add_hit(32'h000);
      add_hit(32'h004);
      add_miss(32'h080, 28'h008);
      // Flush in IDLE
      add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 28'h0);
      add_miss(32'h000, 28'h000);
      // Flush during the 2nd MEM_READ cycle discards the fill
      add_vec(1'b1, 32'h200, 1'b0, 1'b1, 32'h0, 1'b0, 28'h0);
      mc++;
      add_vec(1'b1, 32'h200, 1'b0, 1'b1, 32'h0, 1'b1, 28'h020);
      add_vec(1'b1, 32'h200, 1'b1, 1'b1, 32'h0, 1'b1, 28'h020);
      add_vec(1'b1, 32'h200, 1'b0, 1'b1, 32'h0, 1'b1, 28'h020);
      add_vec(1'b1, 32'h200, 1'b0, 1'b1, 32'h0, 1'b1, 28'h020);
      add_miss(32'h200, 28'h020);
      add_miss(32'h004, 28'h000);
      run_tbl();

      // Async reset in the middle of a fill
      read    = 1'b1;
      address = 32'h084;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      chk("pre-reset mem_read", {31'b0, mem_read}, 32'd1);
      #2;
      reset = 1'b1;
      read  = 1'b0;
      #1;
      chk("reset mem_read", {31'b0, mem_read}, 32'd0);
      chk("reset busywait", {31'b0, busywait}, 32'd0);
      chk("reset mem_address", {4'b0, mem_address}, 32'd0);
      chk("reset hit_count", hit_count, 32'd0);
      chk("reset miss_count", miss_count, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      hc = 0;
      mc = 0;
      add_miss(32'h084, 28'h008);
      run_tbl();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
